// File: rtl/redmule_mx_encoder.sv
// Streaming FP16 -> MX encoder: NUM_GROUPS beats of NUM_LANES FP16 lanes become one E4M3 value word
// plus one E8M0 shared exponent per beat. Define MX_ENC_RNE_EN for round-to-nearest-even mantissas.
module redmule_mx_encoder #(
    parameter int DATA_W     = 256,
    parameter int BITW       = 16,
    parameter int NUM_LANES  = 8,
    parameter int NUM_ELEMS  = DATA_W / 8,
    parameter int NUM_GROUPS = NUM_ELEMS / NUM_LANES
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        fp16_valid_i,
    output logic                        fp16_ready_o,
    input  logic [NUM_LANES*BITW-1:0]   fp16_data_i,
    output logic                        mx_val_valid_o,
    input  logic                        mx_val_ready_i,
    output logic [DATA_W-1:0]           mx_val_data_o,
    output logic                        mx_exp_valid_o,
    input  logic                        mx_exp_ready_i,
    output logic [NUM_GROUPS*8-1:0]     mx_exp_data_o
);

    localparam int GRP_W = NUM_LANES * 8;
    localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GROUPS - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    state_e                     state_r;
    logic [CNT_W-1:0]           group_cnt_r;
    logic                       ready_r;
    logic                       val_valid_r;
    logic                       exp_valid_r;
    logic [DATA_W-1:0]          val_data_r;
    logic [NUM_GROUPS*8-1:0]    exp_data_r;

    logic [5:0]                 beat_info_s;
    logic [7:0]                 enc_exp_s;
    logic [GRP_W-1:0]           enc_grp_s;
    logic                       accept_s;
    logic                       val_done_s;
    logic                       exp_done_s;

    // Returns {has_normal_lane, largest biased exponent among normal lanes}.
    function automatic logic [5:0] beat_emax(input logic [NUM_LANES*BITW-1:0] beat);
        logic [4:0] e;
        logic [4:0] emax;
        logic       found;
        emax  = 5'd0;
        found = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            e = beat[BITW*l+10 +: 5];
            if ((e != 5'd0) && (e != 5'd31)) begin
                found = 1'b1;
                if (e > emax) begin
                    emax = e;
                end
            end
        end
        return {found, emax};
    endfunction

    // One FP16 lane to E4M3 relative to the group maximum; no FP8 subnormals, clamp to +-448.
    function automatic logic [7:0] encode_lane(input logic [15:0] h, input logic [4:0] emax);
        logic signed [5:0] ef;
        logic [7:0]        res;
`ifdef MX_ENC_RNE_EN
        logic              round_up;
        logic [3:0]        mf_rnd;
        logic signed [5:0] ef_rnd;
`endif
        ef = $signed({1'b0, h[14:10]}) - $signed({1'b0, emax}) + 6'sd15;
        if (h[14:10] == 5'd0) begin
            res = {h[15], 7'h00};
        end else if (h[14:10] == 5'd31) begin
            res = {h[15], 7'h7F};
        end else if (ef <= 6'sd0) begin
            res = {h[15], 7'h00};
        end else begin
`ifdef MX_ENC_RNE_EN
            round_up = h[6] & ((|h[5:0]) | h[7]);
            mf_rnd   = {1'b0, h[9:7]} + {3'b000, round_up};
            ef_rnd   = ef + $signed({5'b00000, mf_rnd[3]});
            if ((ef_rnd > 6'sd15) || ((ef_rnd == 6'sd15) && (mf_rnd[2:0] == 3'b111))) begin
                res = {h[15], 7'h7E};
            end else begin
                res = {h[15], ef_rnd[3:0], mf_rnd[2:0]};
            end
`else
            if ((ef == 6'sd15) && (h[9:7] == 3'b111)) begin
                res = {h[15], 7'h7E};
            end else begin
                res = {h[15], ef[3:0], h[9:7]};
            end
`endif
        end
        return res;
    endfunction

    // Combinational encode of the beat currently on the input.
    always_comb begin
        beat_info_s = beat_emax(fp16_data_i);
        if (beat_info_s[5]) begin
            enc_exp_s = {3'b000, beat_info_s[4:0]} + 8'd104;
        end else begin
            enc_exp_s = 8'd0;
        end
        enc_grp_s = {GRP_W{1'b0}};
        for (int l = 0; l < NUM_LANES; l++) begin
            enc_grp_s[8*l +: 8] = encode_lane(fp16_data_i[BITW*l +: BITW], beat_info_s[4:0]);
        end
    end

    // Handshake qualifiers; ready_r is only ever high in COLLECT.
    always_comb begin
        accept_s   = ready_r & fp16_valid_i;
        val_done_s = ~val_valid_r | mx_val_ready_i;
        exp_done_s = ~exp_valid_r | mx_exp_ready_i;
    end

    // Collect/emit state machine with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= COLLECT;
            group_cnt_r <= {CNT_W{1'b0}};
            ready_r     <= 1'b0;
            val_valid_r <= 1'b0;
            exp_valid_r <= 1'b0;
            val_data_r  <= {DATA_W{1'b0}};
            exp_data_r  <= {(NUM_GROUPS*8){1'b0}};
        end else begin
            case (state_r)
                COLLECT: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        for (int g = 0; g < NUM_GROUPS; g++) begin
                            if (group_cnt_r == CNT_W'(g)) begin
                                val_data_r[GRP_W*g +: GRP_W] <= enc_grp_s;
                                exp_data_r[8*g +: 8]         <= enc_exp_s;
                            end
                        end
                        if (group_cnt_r == LAST_GRP) begin
                            group_cnt_r <= {CNT_W{1'b0}};
                            state_r     <= EMIT;
                            ready_r     <= 1'b0;
                            val_valid_r <= 1'b1;
                            exp_valid_r <= 1'b1;
                        end else begin
                            group_cnt_r <= group_cnt_r + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    ready_r <= 1'b0;
                    if (val_valid_r && mx_val_ready_i) begin
                        val_valid_r <= 1'b0;
                    end
                    if (exp_valid_r && mx_exp_ready_i) begin
                        exp_valid_r <= 1'b0;
                    end
                    if (val_done_s && exp_done_s) begin
                        state_r <= COLLECT;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= COLLECT;
                    group_cnt_r <= {CNT_W{1'b0}};
                    ready_r     <= 1'b0;
                    val_valid_r <= 1'b0;
                    exp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign fp16_ready_o   = ready_r;
    assign mx_val_valid_o = val_valid_r;
    assign mx_val_data_o  = val_data_r;
    assign mx_exp_valid_o = exp_valid_r;
    assign mx_exp_data_o  = exp_data_r;

endmodule

// File: tb/tb_redmule_mx_encoder.sv
// Scoreboard bench for redmule_mx_encoder: directed blocks, back-pressure, mid-block reset and
// randomized beats checked against an integer reference of the MX quantization rules.
module tb_redmule_mx_encoder;

    localparam int DATA_W     = 256;
    localparam int BITW       = 16;
    localparam int NUM_LANES  = 8;
    localparam int NUM_GROUPS = 4;
    localparam int BEAT_W     = NUM_LANES * BITW;
    localparam int GRP_W      = NUM_LANES * 8;
    localparam int EXP_W      = NUM_GROUPS * 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fp16_valid = 1'b0;
    logic              fp16_ready;
    logic [BEAT_W-1:0] fp16_data = '0;
    logic              mx_val_valid;
    logic              mx_val_ready = 1'b0;
    logic [DATA_W-1:0] mx_val_data;
    logic              mx_exp_valid;
    logic              mx_exp_ready = 1'b0;
    logic [EXP_W-1:0]  mx_exp_data;

    logic rdy_mode = 1'b0;
    logic val_rdy_cfg = 1'b1;
    logic exp_rdy_cfg = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_val_q[$];
    logic [EXP_W-1:0]  exp_exp_q[$];

    logic [DATA_W-1:0] m_val = '0;
    logic [EXP_W-1:0]  m_exp = '0;
    int                m_cnt = 0;

    redmule_mx_encoder #(
        .DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fp16_valid_i   (fp16_valid),
        .fp16_ready_o   (fp16_ready),
        .fp16_data_i    (fp16_data),
        .mx_val_valid_o (mx_val_valid),
        .mx_val_ready_i (mx_val_ready),
        .mx_val_data_o  (mx_val_data),
        .mx_exp_valid_o (mx_exp_valid),
        .mx_exp_ready_i (mx_exp_ready),
        .mx_exp_data_o  (mx_exp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: one lane quantized from the value rules with integer arithmetic.
    function automatic logic [7:0] ref_lane(input logic [15:0] h, input int emax);
        int s, e, m, ef, q, mag;
        s = int'(h[15]);
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) return 8'(s * 128);
        if (e == 31) return 8'(s * 128 + 127);
        ef = e - emax + 15;
        if (ef <= 0) return 8'(s * 128);
        q = m / 128;
`ifdef MX_ENC_RNE_EN
        if (((m % 128) > 64) || (((m % 128) == 64) && (q % 2 == 1))) q++;
        if (q == 8) begin
            q = 0;
            ef++;
        end
`endif
        if ((ef > 15) || ((ef == 15) && (q == 7))) mag = 126;
        else mag = ef * 8 + q;
        return 8'(s * 128 + mag);
    endfunction

    task automatic model_beat(input logic [BEAT_W-1:0] d);
        int emax;
        int e;
        logic [GRP_W-1:0] grp;
        emax = -1;
        for (int l = 0; l < NUM_LANES; l++) begin
            e = int'(d[BITW*l+10 +: 5]);
            if ((e != 0) && (e != 31) && (e > emax)) emax = e;
        end
        for (int l = 0; l < NUM_LANES; l++) grp[8*l +: 8] = ref_lane(d[BITW*l +: BITW], emax);
        m_val[GRP_W*m_cnt +: GRP_W] = grp;
        m_exp[8*m_cnt +: 8] = (emax < 0) ? 8'd0 : 8'(emax + 104);
        m_cnt++;
        if (m_cnt == NUM_GROUPS) begin
            exp_val_q.push_back(m_val);
            exp_exp_q.push_back(m_exp);
            m_cnt = 0;
        end
    endtask

    function automatic logic [15:0] rand_lane(input int base_e);
        int k, e;
        logic [9:0] m;
        logic s;
        logic [4:0] e5;
        k = int'($urandom_range(0, 15));
        s = 1'($urandom_range(0, 1));
        m = 10'($urandom_range(0, 1023));
        if (k == 0) return {s, 15'd0};
        if (k == 1) return {s, 5'd0, m};
        if (k == 2) return {s, 5'd31, m};
        if (k == 3) return 16'($urandom);
        e = base_e - int'($urandom_range(0, 4));
        if (e < 1) e = 1;
        e5 = 5'(e);
        return {s, e5, m};
    endfunction

    // Ready drivers, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            mx_val_ready = ($urandom_range(0, 3) != 0);
            mx_exp_ready = ($urandom_range(0, 3) != 0);
        end else begin
            mx_val_ready = val_rdy_cfg;
            mx_exp_ready = exp_rdy_cfg;
        end
    end

    // Monitor: pop the scoreboard on each handshake, and check held data stays stable.
    logic              val_hold = 1'b0;
    logic              exp_hold = 1'b0;
    logic [DATA_W-1:0] val_prev = '0;
    logic [EXP_W-1:0]  exp_prev = '0;
    always @(negedge clk) begin
        if (rst) begin
            val_hold = 1'b0;
            exp_hold = 1'b0;
        end else begin
            if (mx_val_valid) begin
                if (val_hold) check("val_stable", mx_val_data, val_prev);
                if (mx_val_ready) begin
                    if (exp_val_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL val_unexpected: got %h, expected no output", mx_val_data);
                    end else begin
                        check("val_data", mx_val_data, exp_val_q.pop_front());
                    end
                    val_hold = 1'b0;
                end else begin
                    val_hold = 1'b1;
                    val_prev = mx_val_data;
                end
            end else begin
                val_hold = 1'b0;
            end
            if (mx_exp_valid) begin
                if (exp_hold) check("exp_stable", 256'(mx_exp_data), 256'(exp_prev));
                if (mx_exp_ready) begin
                    if (exp_exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL exp_unexpected: got %h, expected no output", mx_exp_data);
                    end else begin
                        check("exp_data", 256'(mx_exp_data), 256'(exp_exp_q.pop_front()));
                    end
                    exp_hold = 1'b0;
                end else begin
                    exp_hold = 1'b1;
                    exp_prev = mx_exp_data;
                end
            end else begin
                exp_hold = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [BEAT_W-1:0] d, input bit use_model);
        int waitc;
        waitc = 0;
        @(negedge clk);
        fp16_valid = 1'b1;
        fp16_data  = d;
        while (!fp16_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (waitc >= 200) begin
            errors++;
            $display("FAIL beat_accept_timeout: got ready=%0b after %0d cycles, expected ready", fp16_ready, waitc);
        end
        @(posedge clk);
        if (use_model) model_beat(d);
        #1 fp16_valid = 1'b0;
    endtask

    task automatic send_block(input logic [4*BEAT_W-1:0] blk, input bit use_model);
        for (int g = 0; g < NUM_GROUPS; g++) send_beat(blk[g*BEAT_W +: BEAT_W], use_model);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_val_q.size() != 0 || exp_exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", exp_val_q.size(), exp_exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [BEAT_W-1:0] b1;
    logic [GRP_W-1:0]  g1;
    logic [BEAT_W-1:0] bp;

    initial begin
        b1 = {16'h3A00, 16'h4100, 16'h0000, 16'h3800, 16'hBC00, 16'h4000, 16'h3E00, 16'h3C00};
        g1 = {8'h6C, 8'h7A, 8'h00, 8'h68, 8'hF0, 8'h78, 8'h74, 8'h70};

        // Reset state and release
        repeat (2) @(negedge clk);
        check("rst_val_valid", 256'(mx_val_valid), 256'(1'b0));
        check("rst_exp_valid", 256'(mx_exp_valid), 256'(1'b0));
        check("rst_ready", 256'(fp16_ready), 256'(1'b0));
        check("rst_val_data", mx_val_data, 256'(1'b0));
        check("rst_exp_data", 256'(mx_exp_data), 256'(1'b0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 256'(fp16_ready), 256'(1'b1));

        // Block 1: mixed lanes, latency and return to COLLECT
        exp_val_q.push_back({4{g1}});
        exp_exp_q.push_back(32'h78787878);
        send_block({4{b1}}, 1'b0);
        @(negedge clk);
        check("lat_val_valid", 256'(mx_val_valid), 256'(1'b1));
        check("lat_exp_valid", 256'(mx_exp_valid), 256'(1'b1));
        check("lat_ready_low", 256'(fp16_ready), 256'(1'b0));
        @(negedge clk);
        check("post_val_valid", 256'(mx_val_valid), 256'(1'b0));
        check("post_exp_valid", 256'(mx_exp_valid), 256'(1'b0));
        check("post_ready_high", 256'(fp16_ready), 256'(1'b1));

        // Block 2: powers of two per beat
        exp_val_q.push_back({32{8'h78}});
        exp_exp_q.push_back(32'h7A797877);
        send_block({{8{16'h4800}}, {8{16'h4400}}, {8{16'h4000}}, {8{16'h3C00}}}, 1'b0);
        wait_drain();

        // Rounding block
`ifdef MX_ENC_RNE_EN
        exp_val_q.push_back({32{8'h7A}});
`else
        exp_val_q.push_back({32{8'h79}});
`endif
        exp_exp_q.push_back(32'h77777777);
        send_block({4 * NUM_LANES{16'h3CC0}}, 1'b0);
        wait_drain();

        // Edge block: zeros, specials, saturation, flush, subnormals
        send_block({{16'h0001, 16'h3FFF, 16'hFBFF, 16'h7BFF, 16'hF800, 16'h1000, 16'h3C00, 16'h7800},
                    {16'h3800, 16'h3C00, 16'h3C40, 16'h0400, 16'h1000, 16'hBFFF, 16'h3C00, 16'h3FFF},
                    {16'h3C00, 16'h83FF, 16'h03FF, 16'h8000, 16'h3C00, 16'h3C00, 16'hFE00, 16'h7C00},
                    {8{16'h0000}}}, 1'b1);
        wait_drain();

        // Back-pressure on the value port only; a fifth beat must wait
        val_rdy_cfg = 1'b0;
        exp_rdy_cfg = 1'b1;
        send_block({{8{16'h4A00}}, {8{16'hC100}}, {8{16'h3555}}, {8{16'h5123}}}, 1'b1);
        bp = {8{16'h4321}};
        fork
            send_beat(bp, 1'b1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_val_held", 256'(mx_val_valid), 256'(1'b1));
                    check("bp_ready_low", 256'(fp16_ready), 256'(1'b0));
                    if (i > 0) check("bp_exp_dropped", 256'(mx_exp_valid), 256'(1'b0));
                end
                val_rdy_cfg = 1'b1;
            end
        join
        for (int g = 1; g < NUM_GROUPS; g++) send_beat({8{16'h3C00 + 16'(g * 256)}}, 1'b1);
        wait_drain();

        // Reset mid-block discards the partial block
        send_beat({8{16'h4567}}, 1'b0);
        send_beat({8{16'hC89A}}, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_val_data", mx_val_data, 256'(1'b0));
        check("mrst_exp_data", 256'(mx_exp_data), 256'(1'b0));
        check("mrst_ready", 256'(fp16_ready), 256'(1'b0));
        check("mrst_val_valid", 256'(mx_val_valid), 256'(1'b0));
        rst = 1'b0;
        send_block({{8{16'h3800}}, {8{16'h4C00}}, {8{16'hB400}}, {8{16'h2E66}}}, 1'b1);
        wait_drain();

        // Randomized beats with random readies
        rdy_mode = 1'b1;
        for (int n = 0; n < 25 * NUM_GROUPS; n++) begin
            int base_e;
            logic [BEAT_W-1:0] d;
            base_e = int'($urandom_range(1, 30));
            for (int l = 0; l < NUM_LANES; l++) d[BITW*l +: BITW] = rand_lane(base_e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(d, 1'b1);
        end
        rdy_mode = 1'b0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
